// File: rtl/fifo_feeder_l1_pkg.sv
// rtl/fifo_feeder_l1_pkg.sv - shared constants for the 4-lane FIFO feeder
package fifo_feeder_l1_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 4;
  localparam int LANES     = 4;

  // Phase presented to the mux layer: even lanes in PHASE_A, odd lanes in PHASE_B.
  localparam logic PHASE_A = 1'b0;
  localparam logic PHASE_B = 1'b1;

  // Phase during which a given lane is allowed to pop.
  function automatic logic lane_phase(input int lane);
    return (lane % 2 == 0) ? PHASE_A : PHASE_B;
  endfunction

endpackage

// File: rtl/fifo_feeder_l1_lane_fifo.sv
// rtl/fifo_feeder_l1_lane_fifo.sv - one WIDTH x DEPTH lane FIFO with registered head output
module fifo_feeder_l1_lane_fifo
  import fifo_feeder_l1_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             step,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             dvalid,
  output logic             full,
  output logic             overflow,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;
  logic [CNT_W-1:0] count_nxt;

  // Both decisions use pre-edge state: a pop never makes room for a same-edge push.
  assign push_ok = push & ~full;
  assign pop_ok  = step & pop & (count != '0);

  // Net occupancy change for this edge.
  always_comb begin
    count_nxt = count;
    case ({push_ok, pop_ok})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  // Storage array; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers, occupancy, sticky overflow and the registered head word.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      overflow <= 1'b0;
      dout     <= '0;
      dvalid   <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (push & full) begin
        overflow <= 1'b1;
      end
      count <= count_nxt;
      full  <= (count_nxt == CNT_W'(DEPTH));
      // With step low the output stage freezes, keeping a shown word on display.
      if (step) begin
        dvalid <= pop_ok;
        if (pop_ok) begin
          dout   <= mem[rd_ptr];
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/fifo_feeder_l1.sv
// rtl/fifo_feeder_l1.sv - four buffered lanes presented phase-aligned to the 4-to-2 mux layer
module fifo_feeder_l1
  import fifo_feeder_l1_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] Entrada0,
  input  logic [WIDTH-1:0] Entrada1,
  input  logic [WIDTH-1:0] Entrada2,
  input  logic [WIDTH-1:0] Entrada3,
  input  logic             validEntrada0,
  input  logic             validEntrada1,
  input  logic             validEntrada2,
  input  logic             validEntrada3,
  output logic [WIDTH-1:0] Salida0,
  output logic [WIDTH-1:0] Salida1,
  output logic [WIDTH-1:0] Salida2,
  output logic [WIDTH-1:0] Salida3,
  output logic             validSalida0,
  output logic             validSalida1,
  output logic             validSalida2,
  output logic             validSalida3,
  output logic             selector,
  output logic             full0,
  output logic             full1,
  output logic             full2,
  output logic             full3,
  output logic             overflow0,
  output logic             overflow1,
  output logic             overflow2,
  output logic             overflow3
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] din_a   [LANES];
  logic             push_a  [LANES];
  logic [WIDTH-1:0] dout_a  [LANES];
  logic             dvalid_a[LANES];
  logic             full_a  [LANES];
  logic             ovf_a   [LANES];
  logic [CNT_W-1:0] count_a [LANES];
  logic             nsel;

  assign din_a[0]  = Entrada0;
  assign din_a[1]  = Entrada1;
  assign din_a[2]  = Entrada2;
  assign din_a[3]  = Entrada3;
  assign push_a[0] = validEntrada0;
  assign push_a[1] = validEntrada1;
  assign push_a[2] = validEntrada2;
  assign push_a[3] = validEntrada3;

  // The phase the selector moves into decides which lanes pop at this edge.
  assign nsel = ~selector;

  // Selector toggles once per enabled cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      selector <= PHASE_A;
    end else if (enable) begin
      selector <= nsel;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    localparam logic LANE_PH = lane_phase(k);
    fifo_feeder_l1_lane_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (push_a[k]),
      .din      (din_a[k]),
      .step     (enable),
      .pop      (nsel == LANE_PH),
      .dout     (dout_a[k]),
      .dvalid   (dvalid_a[k]),
      .full     (full_a[k]),
      .overflow (ovf_a[k]),
      .count    (count_a[k])
    );
  end

  assign Salida0      = dout_a[0];
  assign Salida1      = dout_a[1];
  assign Salida2      = dout_a[2];
  assign Salida3      = dout_a[3];
  assign validSalida0 = dvalid_a[0];
  assign validSalida1 = dvalid_a[1];
  assign validSalida2 = dvalid_a[2];
  assign validSalida3 = dvalid_a[3];
  assign full0        = full_a[0];
  assign full1        = full_a[1];
  assign full2        = full_a[2];
  assign full3        = full_a[3];
  assign overflow0    = ovf_a[0];
  assign overflow1    = ovf_a[1];
  assign overflow2    = ovf_a[2];
  assign overflow3    = ovf_a[3];

endmodule

// File: tb/tb_fifo_feeder_l1.sv
// tb/tb_fifo_feeder_l1.sv - randomized and directed self-checking bench for fifo_feeder_l1
module tb_fifo_feeder_l1;

  localparam int W = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic [W-1:0] ent [4];
  logic         vent[4];
  logic [W-1:0] sal [4];
  logic         vsal[4];
  logic         full[4];
  logic         ovf [4];
  logic         selector;

  int checks = 0;
  int failures = 0;

  // Reference model: per-lane queues plus the visible output state.
  logic [W-1:0] q[4][$];
  logic [W-1:0] m_sal [4];
  logic         m_vsal[4];
  logic         m_ovf [4];
  logic         m_sel;

  always #5 clk = ~clk;

  fifo_feeder_l1 #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .Entrada0(ent[0]), .Entrada1(ent[1]), .Entrada2(ent[2]), .Entrada3(ent[3]),
    .validEntrada0(vent[0]), .validEntrada1(vent[1]),
    .validEntrada2(vent[2]), .validEntrada3(vent[3]),
    .Salida0(sal[0]), .Salida1(sal[1]), .Salida2(sal[2]), .Salida3(sal[3]),
    .validSalida0(vsal[0]), .validSalida1(vsal[1]),
    .validSalida2(vsal[2]), .validSalida3(vsal[3]),
    .selector(selector),
    .full0(full[0]), .full1(full[1]), .full2(full[2]), .full3(full[3]),
    .overflow0(ovf[0]), .overflow1(ovf[1]), .overflow2(ovf[2]), .overflow3(ovf[3])
  );

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      q[k].delete();
      m_sal[k] = '0; m_vsal[k] = 1'b0; m_ovf[k] = 1'b0;
    end
    m_sel = 1'b0;
  endtask

  // Apply one clock edge with current inputs, advance the model, compare every output.
  task automatic cycle();
    bit was_full[4];
    bit nsel;
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      for (int k = 0; k < 4; k++) was_full[k] = (q[k].size() == D);
      if (enable) begin
        nsel = ~m_sel;
        m_sel = nsel;
        for (int k = 0; k < 4; k++) begin
          if ((k % 2) == int'(nsel) && q[k].size() > 0) begin
            m_sal[k] = q[k].pop_front();
            m_vsal[k] = 1'b1;
          end else begin
            m_vsal[k] = 1'b0;
          end
        end
      end
      for (int k = 0; k < 4; k++) begin
        if (vent[k]) begin
          if (was_full[k]) m_ovf[k] = 1'b1;
          else q[k].push_back(ent[k]);
        end
      end
    end
    #1;
    checks++;
    if (selector !== m_sel) begin
      failures++;
      $display("FAIL selector t=%0t got=%0b exp=%0b", $time, selector, m_sel);
    end
    for (int k = 0; k < 4; k++) begin
      checks += 4;
      if (sal[k] !== m_sal[k]) begin
        failures++;
        $display("FAIL salida%0d t=%0t got=%02h exp=%02h", k, $time, sal[k], m_sal[k]);
      end
      if (vsal[k] !== m_vsal[k]) begin
        failures++;
        $display("FAIL valid%0d t=%0t got=%0b exp=%0b", k, $time, vsal[k], m_vsal[k]);
      end
      if (full[k] !== (q[k].size() == D)) begin
        failures++;
        $display("FAIL full%0d t=%0t got=%0b exp=%0b", k, $time, full[k], q[k].size() == D);
      end
      if (ovf[k] !== m_ovf[k]) begin
        failures++;
        $display("FAIL overflow%0d t=%0t got=%0b exp=%0b", k, $time, ovf[k], m_ovf[k]);
      end
    end
  endtask

  task automatic idle_inputs();
    for (int k = 0; k < 4; k++) begin
      vent[k] = 1'b0; ent[k] = '0;
    end
  endtask

  task automatic push_one(input int lane, input logic [W-1:0] val, input logic en);
    idle_inputs();
    enable = en;
    vent[lane] = 1'b1; ent[lane] = val;
    cycle();
    idle_inputs();
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1; enable = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1;
    for (int c = 0; c < 2; c++) begin
      for (int k = 0; k < 4; k++) begin
        vent[k] = 1'b1; ent[k] = W'($urandom);
      end
      cycle();
    end
    reset = 1'b0;
    idle_inputs();
    checks++;
    if (selector !== 1'b0) begin
      failures++;
      $display("FAIL reset_selector got=%0b exp=0", selector);
    end
    for (int c = 0; c < 6; c++) begin
      cycle();
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (vsal[k] !== 1'b0) begin
          failures++;
          $display("FAIL reset_no_accept lane%0d got=%0b exp=0", k, vsal[k]);
        end
      end
    end
  endtask

  task automatic test_phase();
    do_reset();
    enable = 1'b0;
    vent[0] = 1'b1; ent[0] = 8'hA0;
    vent[1] = 1'b1; ent[1] = 8'hB1;
    cycle();
    idle_inputs();
    enable = 1'b1;
    cycle();
    checks++;
    if (selector !== 1'b1 || vsal[1] !== 1'b1 || sal[1] !== 8'hB1 || vsal[0] || vsal[2] || vsal[3]) begin
      failures++;
      $display("FAIL phase_b sel=%0b v1=%0b s1=%02h exp sel=1 v1=1 s1=b1", selector, vsal[1], sal[1]);
    end
    cycle();
    checks++;
    if (selector !== 1'b0 || vsal[0] !== 1'b1 || sal[0] !== 8'hA0 || vsal[1] || vsal[2] || vsal[3]) begin
      failures++;
      $display("FAIL phase_a sel=%0b v0=%0b s0=%02h exp sel=0 v0=1 s0=a0", selector, vsal[0], sal[0]);
    end
  endtask

  task automatic test_fill_overflow();
    logic [W-1:0] seen[$];
    do_reset();
    for (int i = 0; i < 4; i++) push_one(2, W'(8'h10 + i), 1'b0);
    checks++;
    if (full[2] !== 1'b1) begin
      failures++;
      $display("FAIL fill_full2 got=%0b exp=1", full[2]);
    end
    push_one(2, 8'h14, 1'b0);
    checks++;
    if (ovf[2] !== 1'b1) begin
      failures++;
      $display("FAIL fill_overflow2 got=%0b exp=1", ovf[2]);
    end
    enable = 1'b1;
    for (int c = 0; c < 12; c++) begin
      cycle();
      if (vsal[2] && selector == 1'b0) seen.push_back(sal[2]);
    end
    checks++;
    if (seen.size() != 4 || seen[0] !== 8'h10 || seen[1] !== 8'h11 || seen[2] !== 8'h12 || seen[3] !== 8'h13) begin
      failures++;
      $display("FAIL fill_drain_order got_count=%0d exp_count=4 (10,11,12,13)", seen.size());
    end
  endtask

  task automatic test_push_pop_full();
    do_reset();
    for (int i = 0; i < 4; i++) push_one(3, W'(8'h30 + i), 1'b0);
    // selector is 0 here, so the next enabled edge pops odd lanes.
    push_one(3, 8'h55, 1'b1);
    checks++;
    if (ovf[3] !== 1'b1 || full[3] !== 1'b0) begin
      failures++;
      $display("FAIL pushpop_full ovf3=%0b full3=%0b exp ovf3=1 full3=0", ovf[3], full[3]);
    end
    push_one(3, 8'h56, 1'b0);
    checks++;
    if (full[3] !== 1'b1) begin
      failures++;
      $display("FAIL pushpop_count3 full3=%0b exp=1", full[3]);
    end
    do_reset();
    push_one(3, 8'h60, 1'b0);
    push_one(3, 8'h61, 1'b0);
    push_one(3, 8'h62, 1'b1);
    idle_inputs();
    enable = 1'b1;
    for (int c = 0; c < 8; c++) cycle();
  endtask

  task automatic test_freeze();
    logic [W-1:0] s1;
    do_reset();
    push_one(1, 8'h7E, 1'b0);
    push_one(1, 8'h7F, 1'b0);
    enable = 1'b1;
    cycle();
    s1 = sal[1];
    checks++;
    if (vsal[1] !== 1'b1 || s1 !== 8'h7E) begin
      failures++;
      $display("FAIL freeze_setup v1=%0b s1=%02h exp v1=1 s1=7e", vsal[1], s1);
    end
    enable = 1'b0;
    for (int c = 0; c < 3; c++) begin
      for (int k = 0; k < 4; k++) begin
        vent[k] = 1'b1; ent[k] = W'($urandom);
      end
      cycle();
      checks++;
      if (vsal[1] !== 1'b1 || sal[1] !== 8'h7E || selector !== 1'b1) begin
        failures++;
        $display("FAIL freeze_hold c=%0d v1=%0b s1=%02h sel=%0b exp 1/7e/1", c, vsal[1], sal[1], selector);
      end
    end
    idle_inputs();
    enable = 1'b1;
    for (int c = 0; c < 10; c++) cycle();
  endtask

  task automatic test_reset_midstream();
    do_reset();
    enable = 1'b0;
    for (int c = 0; c < 2; c++) begin
      for (int k = 0; k < 4; k++) begin
        vent[k] = 1'b1; ent[k] = W'($urandom);
      end
      cycle();
    end
    do_reset();
    for (int c = 0; c < 20; c++) begin
      enable = 1'($urandom_range(0, 3) != 0);
      for (int k = 0; k < 4; k++) begin
        vent[k] = 1'($urandom_range(0, 1)); ent[k] = W'($urandom);
      end
      cycle();
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      reset = 1'($urandom_range(0, 99) == 0);
      enable = 1'($urandom_range(0, 3) != 0);
      for (int k = 0; k < 4; k++) begin
        vent[k] = 1'($urandom_range(0, 2) != 0); ent[k] = W'($urandom);
      end
      cycle();
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0;
    idle_inputs();
    model_reset();
    test_reset();
    test_phase();
    test_fill_overflow();
    test_push_pop_full();
    test_freeze();
    test_reset_midstream();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
